// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: memory-op encoding, EX/MEM entry layout and default widths.
package pipe_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_W  = 5;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2,
    MEM_RSVD  = 2'd3
  } mem_op_e;

  typedef struct packed {
    logic [DEF_REG_W-1:0]  dest;
    logic                  we;
    logic [DEF_DATA_W-1:0] wdata;
    mem_op_e               mem_op;
    logic [DEF_DATA_W-1:0] mem_addr;
  } ex_mem_t;

  // Flattened entry width for non-default parameterisations of the stage.
  function automatic int entry_w(int data_w, int reg_w);
    return reg_w + 1 + data_w + 2 + data_w;
  endfunction

endpackage

// File: rtl/ex_mem_slot.sv
// One pipeline entry register: clear/reset zero the payload, drop only invalidates it.
module ex_mem_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic         drop,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (drop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with valid/ready handshake, flush and forwarding tap.
// Define EX_MEM_SKID_EN for a 2-entry skid buffer with a registered in_ready.
module ex_mem_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_W-1:0]  dest_addr,
  input  logic              write_or_not,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        mem_op,
  input  logic [DATA_W-1:0] mem_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REG_W-1:0]  dest_addr_output,
  output logic              write_or_not_output,
  output logic [DATA_W-1:0] wdata_output,
  output logic [1:0]        mem_op_output,
  output logic [DATA_W-1:0] mem_addr_output,
  output logic              fwd_en
);

  localparam int EW = entry_w(DATA_W, REG_W);

  logic [EW-1:0] in_entry;
  logic [EW-1:0] main_d;
  logic [EW-1:0] main_q;
  logic          main_valid;
  logic          main_load;
  logic          main_drop;
  logic          transfer;
  logic          consume;

  assign in_entry = {dest_addr, write_or_not, wdata, mem_op, mem_addr};
  assign transfer = in_valid & in_ready;
  assign consume  = main_valid & out_ready;

`ifdef EX_MEM_SKID_EN
  logic [EW-1:0] skid_q;
  logic          skid_valid;
  logic          skid_load;
  logic          skid_drop;

  // Skid occupancy is the only state that can refuse input, so ready never sees out_ready.
  assign in_ready  = !rst & !skid_valid;
  assign skid_drop = consume & skid_valid;

  always_comb begin
    main_load = 1'b0;
    main_d    = in_entry;
    skid_load = 1'b0;
    if (consume && skid_valid) begin
      main_load = 1'b1;
      main_d    = skid_q;
    end else if (transfer && (!main_valid || consume)) begin
      main_load = 1'b1;
    end else if (transfer) begin
      skid_load = 1'b1;
    end
  end

  assign main_drop = consume & !main_load;

  ex_mem_slot #(.W(EW)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .load  (skid_load),
    .drop  (skid_drop),
    .d     (in_entry),
    .valid (skid_valid),
    .q     (skid_q)
  );
`else
  assign in_ready  = !rst & (out_ready | !main_valid);
  assign main_load = transfer;
  assign main_d    = in_entry;
  assign main_drop = consume & !transfer;
`endif

  ex_mem_slot #(.W(EW)) u_main (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .load  (main_load),
    .drop  (main_drop),
    .d     (main_d),
    .valid (main_valid),
    .q     (main_q)
  );

  assign {dest_addr_output, write_or_not_output, wdata_output, mem_op_output, mem_addr_output} = main_q;
  assign out_valid = main_valid;
  // Register 0 is hardwired zero in the register file, so it must never forward.
  assign fwd_en    = main_valid & write_or_not_output & (dest_addr_output != '0);

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage; queue-based reference model plus directed literal checks.
module tb_ex_mem_stage;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, write_or_not, out_valid, out_ready;
  logic [4:0]  dest_addr, dest_addr_output;
  logic [31:0] wdata, mem_addr, wdata_output, mem_addr_output;
  logic [1:0]  mem_op, mem_op_output;
  logic        write_or_not_output, fwd_en;

  int checks = 0;
  int errors = 0;

  ex_mem_t q[$];
  ex_mem_t last;
  bit      model_ok = 1'b0;
  logic [31:0] drained[$];
  logic [31:0] sent[$];
  bit      prod_done;

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .dest_addr(dest_addr), .write_or_not(write_or_not), .wdata(wdata),
    .mem_op(mem_op), .mem_addr(mem_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .dest_addr_output(dest_addr_output), .write_or_not_output(write_or_not_output),
    .wdata_output(wdata_output), .mem_op_output(mem_op_output),
    .mem_addr_output(mem_addr_output), .fwd_en(fwd_en)
  );

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_ready();
    if (rst) return 1'b0;
`ifdef EX_MEM_SKID_EN
    return q.size() < 2;
`else
    return out_ready || (q.size() == 0);
`endif
  endfunction

  function automatic ex_mem_t mk(logic [4:0] d, logic we, logic [31:0] wd, logic [1:0] op, logic [31:0] a);
    ex_mem_t e;
    e.dest = d; e.we = we; e.wdata = wd; e.mem_op = mem_op_e'(op); e.mem_addr = a;
    return e;
  endfunction

  // Reference model: a FIFO of accepted entries, head is what memory must see.
  always @(posedge clk) begin : model
    ex_mem_t e;
    bit xfer;
    e = mk(dest_addr, write_or_not, wdata, mem_op, mem_addr);
    xfer = in_valid && exp_ready();
    if (out_valid === 1'b1 && out_ready === 1'b1) drained.push_back(wdata_output);
    if (rst || flush) begin
      q.delete();
      last = '0;
    end else begin
      if (q.size() > 0 && out_ready) last = q.pop_front();
      if (xfer) q.push_back(e);
    end
    model_ok = 1'b1;
  end

  always @(negedge clk) begin : compare
    ex_mem_t p;
    bit v;
    if (model_ok) begin
      v = q.size() > 0;
      p = v ? q[0] : last;
      chk("out_valid", 64'(out_valid), 64'(v));
      chk("dest", 64'(dest_addr_output), 64'(p.dest));
      chk("we", 64'(write_or_not_output), 64'(p.we));
      chk("wdata", 64'(wdata_output), 64'(p.wdata));
      chk("mem_op", 64'(mem_op_output), 64'(p.mem_op));
      chk("mem_addr", 64'(mem_addr_output), 64'(p.mem_addr));
      chk("fwd_en", 64'(fwd_en), 64'(v && p.we && p.dest != 5'd0));
      chk("in_ready", 64'(in_ready), 64'(exp_ready()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(ex_mem_t e);
    dest_addr = e.dest; write_or_not = e.we; wdata = e.wdata;
    mem_op = e.mem_op; mem_addr = e.mem_addr;
  endtask

  task automatic send(ex_mem_t e);
    int n;
    bit acc;
    set_in(e);
    in_valid = 1'b1;
    n = 0;
    acc = 1'b0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    in_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout: got no accept expected accept of wdata %0h", e.wdata);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_in(mk(5'd0, 1'b0, 32'd0, 2'd0, 32'd0));
    step(); step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_fwd_en", 64'(fwd_en), 64'd0);
    chk("rst_wdata", 64'(wdata_output), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // single transfer
    send(mk(5'd5, 1'b1, 32'hDEADBEEF, MEM_NONE, 32'h0));
    chk("t1_out_valid", 64'(out_valid), 64'd1);
    chk("t1_fwd_en", 64'(fwd_en), 64'd1);
    chk("t1_wdata", 64'(wdata_output), 64'hDEADBEEF);
    chk("t1_dest", 64'(dest_addr_output), 64'd5);
    step();

    // back-pressure
    out_ready = 1'b0;
    drained.delete();
    fork
      begin
        for (int v = 1; v <= 3; v++) send(mk(5'd1, 1'b1, 32'(v), MEM_NONE, 32'h0));
      end
      begin
        repeat (4) step();
        chk("bp_hold_wdata", 64'(wdata_output), 64'd1);
        chk("bp_hold_valid", 64'(out_valid), 64'd1);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
      end
    join
    repeat (4) step();
    chk("bp_drain_cnt", 64'(drained.size()), 64'd3);
    for (int i = 0; i < 3 && i < drained.size(); i++)
      chk("bp_drain_order", 64'(drained[i]), 64'(i + 1));

    // flush with full slots and a concurrent transfer
    out_ready = 1'b0;
    send(mk(5'd2, 1'b1, 32'hA1, MEM_LOAD, 32'h20));
`ifdef EX_MEM_SKID_EN
    send(mk(5'd3, 1'b1, 32'hB2, MEM_LOAD, 32'h24));
`endif
    flush = 1'b1;
    set_in(mk(5'd4, 1'b1, 32'h55, MEM_NONE, 32'h0));
    in_valid = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_wdata", 64'(wdata_output), 64'd0);
    chk("fl_dest", 64'(dest_addr_output), 64'd0);
    chk("fl_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (3) step();
    chk("fl_no_55", 64'(out_valid), 64'd0);

    // register zero never forwards
    send(mk(5'd0, 1'b1, 32'd7, MEM_NONE, 32'h0));
    chk("r0_out_valid", 64'(out_valid), 64'd1);
    chk("r0_fwd_en", 64'(fwd_en), 64'd0);

    // store
    send(mk(5'd9, 1'b0, 32'h1234, MEM_STORE, 32'h1000));
    chk("st_fwd_en", 64'(fwd_en), 64'd0);
    chk("st_mem_op", 64'(mem_op_output), 64'd2);
    chk("st_mem_addr", 64'(mem_addr_output), 64'h1000);
    step();

    // reset mid-operation
    out_ready = 1'b0;
    send(mk(5'd6, 1'b1, 32'h66, MEM_NONE, 32'h0));
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("mr_out_valid", 64'(out_valid), 64'd0);
    chk("mr_wdata", 64'(wdata_output), 64'd0);
    chk("mr_in_ready", 64'(in_ready), 64'd1);

    // random streaming
    drained.delete();
    sent.delete();
    prod_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          ex_mem_t e;
          e = mk(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom,
                 2'($urandom_range(0, 3)), $urandom);
          sent.push_back(e.wdata);
          send(e);
          if ($urandom_range(0, 3) == 0) step();
        end
        prod_done = 1'b1;
      end
      begin
        for (int c = 0; c < 5000 && !prod_done; c++) begin
          out_ready = 1'($urandom_range(0, 1));
          step();
        end
      end
    join
    out_ready = 1'b1;
    repeat (5) step();
    chk("st_count", 64'(drained.size()), 64'(sent.size()));
    for (int i = 0; i < sent.size() && i < drained.size(); i++)
      chk("st_order", 64'(drained[i]), 64'(sent[i]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
